// File: rtl/ceas_pkg.sv
// rtl/ceas_pkg.sv - shared constants and segment encoder for the ceas_afisaj clock
package ceas_pkg;

    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] ORE_MAX  = 5'd23;
    localparam int         NR_CIFRE = 6;

    // Segment patterns a..g (a is the MSB), active-low
    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;

    function automatic logic [6:0] cod_seg(input logic [3:0] cifra);
        case (cifra)
            4'd0:    cod_seg = SEG_0;
            4'd1:    cod_seg = SEG_1;
            4'd2:    cod_seg = SEG_2;
            4'd3:    cod_seg = SEG_3;
            4'd4:    cod_seg = SEG_4;
            4'd5:    cod_seg = SEG_5;
            4'd6:    cod_seg = SEG_6;
            4'd7:    cod_seg = SEG_7;
            4'd8:    cod_seg = SEG_8;
            4'd9:    cod_seg = SEG_9;
            default: cod_seg = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/conv_bcd.sv
// rtl/conv_bcd.sv - combinational 6-bit binary to two-digit BCD converter
module conv_bcd
    import ceas_pkg::*;
(
    input  logic [5:0] bin,
    output logic [3:0] zeci,
    output logic [3:0] unitati
);

    assign zeci    = 4'(bin / 6'd10);
    assign unitati = 4'(bin % 6'd10);

endmodule

// File: rtl/ceas_afisaj.sv
// rtl/ceas_afisaj.sv - minutes/hours clock with 6-digit multiplexed display; CEAS_12H_EN selects 12-hour display
module ceas_afisaj
    import ceas_pkg::*;
#(
    parameter int DIV_SCAN = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] secunde,
    input  logic       carry_in,
    input  logic       btn_min,
    input  logic       btn_ora,
    output logic [5:0] minute,
    output logic [4:0] ore,
    output logic       carry_out,
    output logic [5:0] anod,
    output logic [6:0] segmente,
    output logic       pm
);

    localparam int CW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;

    logic          carry_q;
    logic          carry_hold;
    logic          inc_min;
    logic          min_step;
    logic          ora_din_min;
    logic          ora_step;
    logic [CW-1:0] cnt_scan;
    logic [2:0]    index;

    logic [3:0] sec_z, sec_u, min_z, min_u, ore_z, ore_u;
    logic [5:0] ore_afis;
    logic       pm_next;
    logic [3:0] cifra;
    logic       liniuta;

    // carry_hold masks a carry_in that was already high across reset release
    always_comb begin
        inc_min     = carry_in & ~carry_q & ~carry_hold;
        min_step    = inc_min | btn_min;
        ora_din_min = inc_min & (minute == MIN_MAX);
        ora_step    = ora_din_min | btn_ora;
    end

    conv_bcd u_bcd_sec (.bin(secunde),          .zeci(sec_z), .unitati(sec_u));
    conv_bcd u_bcd_min (.bin(minute),           .zeci(min_z), .unitati(min_u));
    conv_bcd u_bcd_ore (.bin(ore_afis),         .zeci(ore_z), .unitati(ore_u));

`ifdef CEAS_12H_EN
    always_comb begin
        ore_afis = {1'b0, ore};
        if (ore == 5'd0)
            ore_afis = 6'd12;
        else if (ore > 5'd12)
            ore_afis = {1'b0, ore - 5'd12};
        pm_next = (ore >= 5'd12);
    end
`else
    always_comb begin
        ore_afis = {1'b0, ore};
        pm_next  = 1'b0;
    end
`endif

    always_comb begin
        cifra   = 4'd0;
        liniuta = 1'b0;
        case (index)
            3'd0:    begin cifra = sec_u; liniuta = (secunde > MIN_MAX); end
            3'd1:    begin cifra = sec_z; liniuta = (secunde > MIN_MAX); end
            3'd2:    cifra = min_u;
            3'd3:    cifra = min_z;
            3'd4:    cifra = ore_u;
            default: cifra = ore_z;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            minute     <= '0;
            ore        <= '0;
            carry_q    <= 1'b0;
            carry_hold <= carry_in;
            carry_out  <= 1'b0;
            cnt_scan   <= '0;
            index      <= '0;
            anod       <= '1;
            segmente   <= '1;
            pm         <= 1'b0;
        end else begin
            carry_q    <= carry_in;
            carry_hold <= carry_hold & carry_in;

            if (min_step)
                minute <= (minute == MIN_MAX) ? 6'd0 : minute + 6'd1;
            if (ora_step)
                ore <= (ore == ORE_MAX) ? 5'd0 : ore + 5'd1;
            // Only a minute-generated hour wrap ends the day; button-set hours never do
            carry_out <= ora_din_min & (ore == ORE_MAX);

            if (cnt_scan == CW'(DIV_SCAN - 1)) begin
                cnt_scan <= '0;
                index    <= (index == 3'(NR_CIFRE - 1)) ? 3'd0 : index + 3'd1;
            end else begin
                cnt_scan <= cnt_scan + 1'b1;
            end

            anod     <= ~(6'b000001 << index);
            segmente <= liniuta ? SEG_DASH : cod_seg(cifra);
            pm       <= pm_next;
        end
    end

endmodule

// File: tb/tb_ceas_afisaj.sv
// tb/tb_ceas_afisaj.sv - self-checking bench for ceas_afisaj (honours CEAS_12H_EN)
module tb_ceas_afisaj;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] secunde;
    logic       carry_in;
    logic       btn_min;
    logic       btn_ora;
    logic [5:0] minute;
    logic [4:0] ore;
    logic       carry_out;
    logic [5:0] anod;
    logic [6:0] segmente;
    logic       pm;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;
    int co_cnt   = 0;

    typedef struct {
        logic [2:0] idx;
        logic [5:0] anod;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl[6];

    ceas_afisaj #(.DIV_SCAN(4)) dut (
        .clock(clock), .reset(reset), .secunde(secunde), .carry_in(carry_in),
        .btn_min(btn_min), .btn_ora(btn_ora), .minute(minute), .ore(ore),
        .carry_out(carry_out), .anod(anod), .segmente(segmente), .pm(pm)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        n_cyc++;
        if (carry_out) co_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cyc  = 0;
        co_cnt = 0;
    endtask

    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) begin
            btn_min = 1'b1; tick();
            btn_min = 1'b0; tick();
        end
    endtask

    task automatic press_ora(input int n);
        for (int i = 0; i < n; i++) begin
            btn_ora = 1'b1; tick();
            btn_ora = 1'b0; tick();
        end
    endtask

    // After tick n (n>=1 since reset release) anod shows digit ((n-1)/4)%6
    task automatic wait_digit_end(input int d);
        int guard;
        guard = 0;
        while (!((((n_cyc - 1) / 4) % 6 == d) && ((n_cyc - 1) % 4 == 3)) && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL scan_timeout: digit %0d not reached", d);
        end
    endtask

    initial begin
        tbl[0] = '{3'd0, 6'b111110, 7'b0001111};
        tbl[1] = '{3'd1, 6'b111101, 7'b0000110};
        tbl[2] = '{3'd2, 6'b111011, 7'b0100100};
        tbl[3] = '{3'd3, 6'b110111, 7'b0000001};
`ifdef CEAS_12H_EN
        tbl[4] = '{3'd4, 6'b101111, 7'b0010010};
        tbl[5] = '{3'd5, 6'b011111, 7'b0000001};
`else
        tbl[4] = '{3'd4, 6'b101111, 7'b1001100};
        tbl[5] = '{3'd5, 6'b011111, 7'b1001111};
`endif

        reset = 1'b1; secunde = 6'd37; carry_in = 1'b0; btn_min = 1'b0; btn_ora = 1'b0;
        tick();
        tick();
        chk("rst_anod", anod, 6'b111111);
        chk("rst_seg", segmente, 7'b1111111);
        chk("rst_minute", minute, 6'd0);
        chk("rst_ore", ore, 5'd0);
        chk("rst_pm", pm, 1'b0);
        chk("rst_carry_out", carry_out, 1'b0);

        // Reset priority over buttons and carry
        btn_min = 1'b1; btn_ora = 1'b1; carry_in = 1'b1;
        tick();
        chk("rst_prio_min", minute, 6'd0);
        chk("rst_prio_ore", ore, 5'd0);
        btn_min = 1'b0; btn_ora = 1'b0;

        // carry_in high across release: no increment until it falls and rises
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_no_inc", minute, 6'd0);
        carry_in = 1'b0; tick();
        carry_in = 1'b1; tick();
        chk("hold_then_inc", minute, 6'd1);
        carry_in = 1'b0; tick();

        // 60 carry edges -> minute 0, ore 1, no day wrap
        do_reset();
        for (int i = 0; i < 60; i++) begin
            carry_in = 1'b1; tick();
            carry_in = 1'b1; tick();
            carry_in = 1'b0; tick();
        end
        chk("sixty_minute", minute, 6'd0);
        chk("sixty_ore", ore, 5'd1);
        chk("sixty_no_co", co_cnt, 0);

        // Day wrap from 23:59 with a 5-cycle carry_in
        do_reset();
        press_ora(23);
        press_min(59);
        chk("preset_minute", minute, 6'd59);
        chk("preset_ore", ore, 5'd23);
        chk("btn_no_co", co_cnt, 0);
        carry_in = 1'b1; tick();
        chk("wrap_minute", minute, 6'd0);
        chk("wrap_ore", ore, 5'd0);
        chk("wrap_co_now", carry_out, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        carry_in = 1'b0; tick(); tick();
        chk("wrap_co_count", co_cnt, 1);
        chk("wrap_minute_after", minute, 6'd0);
        chk("wrap_ore_after", ore, 5'd0);

        // btn_ora at 23 wraps with no carry_out
        press_ora(23);
        co_cnt = 0;
        press_ora(1);
        chk("btn_ora_wrap", ore, 5'd0);
        chk("btn_ora_no_co", co_cnt, 0);

        // Simultaneous btn_min and carry edge at minute 10
        press_min(10);
        chk("pre_coinc", minute, 6'd10);
        btn_min = 1'b1; carry_in = 1'b1; tick();
        btn_min = 1'b0; carry_in = 1'b0; tick();
        chk("coinc_minute", minute, 6'd11);
        press_min(48);
        chk("pre_btn_wrap", minute, 6'd59);
        press_min(1);
        chk("btn_min_wrap", minute, 6'd0);
        chk("btn_min_wrap_ore", ore, 5'd0);

        // Scan: secunde 37, 05 minutes, 14 hours
        do_reset();
        press_min(5);
        press_ora(14);
        for (int k = 0; k < 6; k++) begin
            wait_digit_end(int'(tbl[k].idx));
            chk($sformatf("scan_anod_%0d", k), anod, tbl[k].anod);
            chk($sformatf("scan_seg_%0d", k), segmente, tbl[k].seg);
        end
`ifdef CEAS_12H_EN
        chk("pm_14h", pm, 1'b1);
`else
        chk("pm_14h", pm, 1'b0);
`endif
        chk("ore_binary", ore, 5'd14);

        // Out-of-range seconds -> dash on both seconds digits
        secunde = 6'd62;
        wait_digit_end(0);
        chk("dash_anod0", anod, 6'b111110);
        chk("dash_seg0", segmente, 7'b1111110);
        wait_digit_end(1);
        chk("dash_seg1", segmente, 7'b1111110);
        wait_digit_end(2);
        chk("dash_min_unaffected", segmente, 7'b0100100);

        // Reset mid-scan
        tick();
        reset = 1'b1; tick();
        chk("midscan_anod", anod, 6'b111111);
        reset = 1'b0; tick();
        chk("midscan_idx0", anod, 6'b111110);
        tick(); tick(); tick();
        chk("midscan_idx0_hold", anod, 6'b111110);
        tick();
        chk("midscan_idx1", anod, 6'b111101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ceas_afisaj.md
CEAS_AFISAJ -- requirements
Module: ceas_afisaj

Interface
REQ-001 Parameter DIV_SCAN, default 50000, SHALL be the number of clock cycles each display digit stays active.
REQ-002 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Port secunde  input  6  SHALL carry the binary seconds value from the upstream seconds counter.
REQ-005 Port carry_in  input  1  SHALL be the upstream seconds-wrap flag; it may stay high for several cycles.
REQ-006 Port btn_min  input  1  SHALL be a synchronous, already-debounced pulse that sets minutes.
REQ-007 Port btn_ora  input  1  SHALL be a synchronous, already-debounced pulse that sets hours.
REQ-008 Port minute  output  6  SHALL be the binary minutes, range 0..59.
REQ-009 Port ore  output  5  SHALL be the binary hours, range 0..23.
REQ-010 Port carry_out  output  1  SHALL be a one-cycle pulse on the day wrap.
REQ-011 Port anod  output  6  SHALL be the digit enables, active-low, one-hot.
REQ-012 Port segmente  output  7  SHALL be segments a..g, active-low.
REQ-013 Port pm  output  1  SHALL be the afternoon indicator (see Configuration).

Function
REQ-014 The block SHALL register carry_in into carry_q each cycle; inc_min = carry_in & ~carry_q, so one increment occurs per rising edge regardless of high duration.
REQ-015 minute SHALL change on the same clock edge at which carry_in is first sampled high.
REQ-016 On inc_min with minute<59: minute+1; with minute=59: minute=0 and hours increment in the same cycle.
REQ-017 On an hour increment with ore<23: ore+1; with ore=23: ore=0 and carry_out=1 for exactly that one cycle.
REQ-018 btn_min SHALL increment minute modulo 60 with no hour carry; btn_ora SHALL increment ore modulo 24 with no carry_out.
REQ-019 When btn_min and inc_min occur in the same cycle, minute SHALL advance by exactly one, and the hour carry SHALL follow inc_min rules.
REQ-020 When btn_ora and a minute-generated hour increment occur in the same cycle, ore SHALL advance by exactly one.
REQ-021 The scan counter SHALL count 0..DIV_SCAN-1; at terminal count, the digit index SHALL advance 0..5 and wrap to 0.
REQ-022 Digit mapping: 0 = seconds units (rightmost), 1 = seconds tens, 2 = minutes units, 3 = minutes tens, 4 = hours units, 5 = hours tens.
REQ-023 anod SHALL drive low only bit[index]; anod and segmente SHALL be registered (1-cycle latency from index/value).
REQ-024 If secunde>59, both seconds digits SHALL show the dash (segment g only) pattern.
REQ-025 Segment codes SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, dash=1111110 (a..g).

Reset
REQ-026 On reset: minute=0, ore=0, carry_q=0, carry_out=0, scan counter=0, index=0, anod=111111, segmente=1111111, pm=0.
REQ-027 Reset SHALL take priority over carry_in, btn_min and btn_ora in the same cycle.
REQ-028 If carry_in is high when reset is released, no increment SHALL occur until carry_in falls and rises again.

Configuration
REQ-029 Macro CEAS_12H_EN defined: the hours digits SHALL show 12-hour format (ore 0 -> 12, 1..12 unchanged, 13..23 -> 1..11), and pm=1 when ore>=12.
REQ-030 Macro CEAS_12H_EN undefined: the hours digits SHALL show ore as 00..23, and pm SHALL be held at 0.
REQ-031 The binary ore output SHALL remain 0..23 in both configurations.

Structure
REQ-032 Package ceas_pkg SHALL hold MIN_MAX=59, ORE_MAX=23, NR_CIFRE=6, the segment code constants, and the dash constant.
REQ-033 Sub-module conv_bcd SHALL convert a 6-bit binary value to tens/units BCD, combinationally; it is instantiated once each for seconds, minutes and hours.

Verification
REQ-034 Reset, then 60 carry_in rising edges -> minute=60 mod 60=0, ore=1, carry_out never asserted.
REQ-035 Preset ore=23, minute=59; carry_in high for 5 cycles -> minute=0, ore=0, carry_out high exactly 1 cycle, no further increments.
REQ-036 btn_min and carry_in edge in the same cycle at minute=10 -> minute=11; btn_min at minute=59 -> minute=0, ore unchanged.
REQ-037 DIV_SCAN=4, secunde=37, minute=5, ore=14 -> anod cycles 111110..011111 every 4 cycles; segments show 7,3,5,0,4,1 (with CEAS_12H_EN: 2,0 for hours, pm=1).
REQ-038 secunde=62 -> seconds digits show 1111110; reset asserted mid-scan -> next cycle anod=111111, index=0.
